// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing parameters for the stopwatch control stage.
package stopwatch_pkg;

  // 2'b11 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES   = 1000000;    // 20 ms at 50 MHz
  localparam int DEF_LONG_PRESS_CYCLES = 100000000;  // 2 s at 50 MHz
  localparam int DEF_TICK_DIV          = 500000;     // 10 ms hundredths tick

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button input and control outputs of the stopwatch control stage.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic   trigger_in;
  logic   run_en;
  logic   tick_out;
  logic   clear_pulse;
  state_t state_out;

  modport master (output trigger_in, input run_en, tick_out, clear_pulse, state_out);
  modport slave  (input trigger_in, output run_en, tick_out, clear_pulse, state_out);

endinterface

// File: rtl/button_debounce.sv
// 2-flop synchroniser, stable-count debouncer and registered rising-edge press pulse.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic trigger_in,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= trigger_in;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Any cycle the input agrees with the accepted level restarts the stability window.
      if (sync2 == level)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/pause FSM, tick prescaler and long-press clear.
// Long-press clear is built only when STOPWATCH_LONGPRESS_CLR_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int TICK_DIV          = DEF_TICK_DIV
) (
  input logic             sys_clk,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV + 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          level, press, lp_hit;
  logic          run_en_q, tick_q, clear_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .trigger_in (bus.trigger_in),
    .level      (level),
    .press      (press)
  );

`ifdef STOPWATCH_LONGPRESS_CLR_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  logic [LW-1:0] lp_cnt;

  // Saturating at the limit keeps the clear to one pulse per hold.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      lp_cnt <= '0;
    else if (!level)
      lp_cnt <= '0;
    else if (lp_cnt != LW'(LONG_PRESS_CYCLES))
      lp_cnt <= lp_cnt + 1'b1;
  end

  assign lp_hit = level && (lp_cnt == LW'(LONG_PRESS_CYCLES - 1));
`else
  logic unused;
  assign unused = &{1'b0, level, LONG_PRESS_CYCLES[0]};
  assign lp_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      run_en_q <= 1'b0;
      tick_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
      // Long-press expiry overrides any press toggle and a coincident terminal count.
      if (lp_hit) begin
        state    <= IDLE;
        presc    <= '0;
        run_en_q <= 1'b0;
        clear_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (press) begin
              state    <= RUNNING;
              run_en_q <= 1'b1;
            end
          end
          RUNNING: begin
            if (presc == PW'(TICK_DIV - 1)) begin
              presc  <= '0;
              tick_q <= 1'b1;
            end else
              presc <= presc + 1'b1;
            if (press) begin
              state    <= PAUSED;
              run_en_q <= 1'b0;
            end
          end
          PAUSED: begin
            if (press) begin
              state    <= RUNNING;
              run_en_q <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            presc    <= '0;
            run_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.run_en      = run_en_q;
  assign bus.tick_out    = tick_q;
  assign bus.clear_pulse = clear_q;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; tick/clear events are checked against a scoreboard queue.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int DEB = 4;
  localparam int LP  = 20;
  localparam int TD  = 5;
  localparam logic [1:0] EV_TICK = 2'b01;
  localparam logic [1:0] EV_CLR  = 2'b10;

  typedef struct {
    int         at;
    logic [1:0] kind;
  } ev_t;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LP),
    .TICK_DIV          (TD)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (sw_if)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the falling edge that follows rising edge number c.
  task automatic go(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic push(input int at, input logic [1:0] kind);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic run);
    chk({tag, "_state"}, sw_if.state_out, st);
    chk({tag, "_run_en"}, sw_if.run_en, run);
  endtask

  always @(negedge sys_clk) begin
    if (!reset && (sw_if.tick_out || sw_if.clear_pulse)) begin
      if (exp_q.size() == 0)
        chk("unexpected_event", {sw_if.clear_pulse, sw_if.tick_out}, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", {sw_if.clear_pulse, sw_if.tick_out}, mon_e.kind);
        chk("event_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish, expected finish by 20000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n;
    sw_if.trigger_in = 1'b0;

    go(1);
    chk_st("reset", 2'b00, 1'b0);
    chk("reset_tick", sw_if.tick_out, 1'b0);
    chk("reset_clear", sw_if.clear_pulse, 1'b0);
    reset = 1'b0;

    // Bounce: two 3-cycle highs never satisfy a 4-cycle window.
    go(3);  sw_if.trigger_in = 1'b1;
    go(6);  sw_if.trigger_in = 1'b0;
    go(7);  sw_if.trigger_in = 1'b1;
    go(10); sw_if.trigger_in = 1'b0;
    go(19); chk_st("bounce", 2'b00, 1'b0);

    // Clean press from IDLE: first sampling edge is 21, run_en on edge 28.
    go(20); sw_if.trigger_in = 1'b1;
    r = 28;
    push(r + 5, EV_TICK); push(r + 10, EV_TICK); push(r + 15, EV_TICK);
    go(r - 1); chk_st("press_early", 2'b00, 1'b0);
    go(r);     chk_st("press", 2'b01, 1'b1);
    go(r + 2); sw_if.trigger_in = 1'b0;

    // Pause with prescaler at 2.
    go(r + 9);  sw_if.trigger_in = 1'b1;
    go(r + 16); chk_st("pause_early", 2'b01, 1'b1);
    go(r + 17); chk_st("pause", 2'b10, 1'b0);
    go(r + 19); sw_if.trigger_in = 1'b0;

    // Resume: partial period finishes 3 cycles after run_en.
    go(r + 30); sw_if.trigger_in = 1'b1;
    push(r + 41, EV_TICK); push(r + 46, EV_TICK); push(r + 51, EV_TICK); push(r + 56, EV_TICK);
    go(r + 37); chk_st("resume_early", 2'b10, 1'b0);
    go(r + 38); chk_st("resume", 2'b01, 1'b1);
    go(r + 40); sw_if.trigger_in = 1'b0;

    // Long hold: press pauses, then clear 20 edges after the debounced rise (edge r+56).
    go(r + 50); sw_if.trigger_in = 1'b1;
`ifdef STOPWATCH_LONGPRESS_CLR_EN
    push(r + 76, EV_CLR);
`endif
    go(r + 58); chk_st("hold_pause", 2'b10, 1'b0);
    go(r + 75); chk_st("hold_pre_clear", 2'b10, 1'b0);
`ifdef STOPWATCH_LONGPRESS_CLR_EN
    go(r + 76); chk_st("hold_clear", 2'b00, 1'b0);
    go(r + 80); sw_if.trigger_in = 1'b0;
    go(r + 88); chk_st("hold_after", 2'b00, 1'b0);
`else
    go(r + 76); chk_st("hold_noclear", 2'b10, 1'b0);
    go(r + 80); sw_if.trigger_in = 1'b0;
    go(r + 88); chk_st("hold_after", 2'b10, 1'b0);
`endif

    // Next press: from IDLE the prescaler restarts at 0; without clear it resumes at 2.
    go(r + 90); sw_if.trigger_in = 1'b1;
`ifdef STOPWATCH_LONGPRESS_CLR_EN
    push(r + 103, EV_TICK); push(r + 108, EV_TICK);
`else
    push(r + 101, EV_TICK); push(r + 106, EV_TICK);
`endif
    go(r + 98);  chk_st("restart", 2'b01, 1'b1);
    go(r + 100); sw_if.trigger_in = 1'b0;

    // Asynchronous reset mid-count with the button held.
    go(r + 110); sw_if.trigger_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk_st("async_reset", 2'b00, 1'b0);
    chk("async_reset_tick", sw_if.tick_out, 1'b0);
    chk("async_reset_clear", sw_if.clear_pulse, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    go(r + 112); reset = 1'b0;
    n = r + 112;
    push(n + 13, EV_TICK);
    go(n + 7); chk_st("post_reset_early", 2'b00, 1'b0);
    go(n + 8); chk_st("post_reset", 2'b01, 1'b1);
    go(n + 14); chk("queue_final", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
